// File: rtl/wlm_iter_pkg.sv
// Shared types and elaboration-time helpers for the iterative word-level
// Montgomery reducer.
package wlm_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CORR = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // One extra bit above 2*LOGQ keeps (acc >> W) + qH*m + c from overflowing.
  function automatic int acc_w(input int logq);
    return 2 * logq + 1;
  endfunction

endpackage

// File: rtl/wlm_iter_if.sv
// Operand/result handshake bundle for wlm_iter; slave is the reducer side.
interface wlm_iter_if #(
  parameter int LOGQ = 60,
  parameter int W    = 17
);
  logic                  in_valid;
  logic                  in_ready;
  logic [LOGQ-W-1:0]     qH;
  logic [2*LOGQ-1:0]     C;
  logic                  out_valid;
  logic                  out_ready;
  logic [LOGQ-1:0]       T;

  modport master (
    output in_valid, qH, C, out_ready,
    input  in_ready, out_valid, T
  );

  modport slave (
    input  in_valid, qH, C, out_ready,
    output in_ready, out_valid, T
  );
endinterface

// File: rtl/wlm_step.sv
// One W-bit Montgomery reduction step: (acc + m*q) / 2^W with q = qH*2^W + 1,
// computed as (acc >> W) + qH*m + (lo != 0) so no wide multiply by q is needed.
module wlm_step
  import wlm_iter_pkg::*;
#(
  parameter int LOGQ = 60,
  parameter int W    = 17
) (
  input  logic [2*LOGQ:0]   acc_i,
  input  logic [LOGQ-W-1:0] qh_i,
  output logic [2*LOGQ:0]   acc_o
);
  localparam int AW = acc_w(LOGQ);

  logic [W-1:0]    lo;
  logic [W-1:0]    m;
  logic            carry;
  logic [LOGQ-1:0] prod;

  always_comb begin
    lo    = acc_i[W-1:0];
    m     = W'(0) - lo;
    carry = |lo;
    prod  = LOGQ'(qh_i) * LOGQ'(m);
    acc_o = (acc_i >> W) + AW'(prod) + AW'(carry);
  end

endmodule

// File: rtl/wlm_iter.sv
// Iterative Montgomery reducer: T = C * 2^(-W*L) mod q, one W-bit step per
// cycle, followed by a single conditional subtraction.
module wlm_iter
  import wlm_iter_pkg::*;
#(
  parameter int LOGQ = 60,
  parameter int W    = 17
) (
  input  logic       clk,
  input  logic       rst,
  wlm_iter_if.slave  bus
);
  localparam int L  = ceil_div(LOGQ, W);
  localparam int AW = acc_w(LOGQ);
  localparam int CW = (L > 1) ? $clog2(L) : 1;
  localparam int HW = LOGQ - W;

  state_e          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d, acc_step;
  logic [HW-1:0]   qh_q, qh_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [LOGQ-1:0] t_q, t_d;
  logic            ov_q, ov_d;
  logic            in_ready;
  logic            accept;
  logic [LOGQ:0]   q_ext, r_ext;
  logic [LOGQ-1:0] r_sub;

  wlm_step #(.LOGQ(LOGQ), .W(W)) u_step (
    .acc_i (acc_q),
    .qh_i  (qh_q),
    .acc_o (acc_step)
  );

  assign in_ready      = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
  assign accept        = bus.in_valid && in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = ov_q;
  assign bus.T         = t_q;

  // R < 2q after the last step, so LOGQ+1 bits cover both compare and subtract.
  assign q_ext = {1'b0, qh_q, {(W-1){1'b0}}, 1'b1};
  assign r_ext = acc_q[LOGQ:0];
  assign r_sub = r_ext[LOGQ-1:0] - q_ext[LOGQ-1:0];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    qh_d    = qh_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: ;
      RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(L - 1)) state_d = CORR;
      end
      CORR: begin
        t_d     = (r_ext >= q_ext) ? r_sub : r_ext[LOGQ-1:0];
        ov_d    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new job may start from IDLE or on the same edge a result is taken.
    if (accept) begin
      acc_d   = AW'(bus.C);
      qh_d    = bus.qH;
      cnt_d   = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      qh_q    <= '0;
      cnt_q   <= '0;
      t_q     <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      qh_q    <= qh_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      ov_q    <= ov_d;
    end
  end

endmodule

// File: tb/tb_wlm_iter.sv
// Directed and randomised checks of wlm_iter at LOGQ=60, W=17 against a
// bit-serial Montgomery reference model.
module tb_wlm_iter;
  localparam int LOGQ = 60;
  localparam int W    = 17;
  localparam int LAT  = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wlm_iter_if #(.LOGQ(LOGQ), .W(W)) bus ();
  wlm_iter #(.LOGQ(LOGQ), .W(W)) u_dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;
  logic [127:0] expq[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: C mod q, then 68 modular halvings.
  function automatic logic [127:0] gold(input logic [127:0] qh, input logic [127:0] c);
    logic [127:0] q, x;
    q = (qh << 17) | 128'd1;
    x = c % q;
    for (int i = 0; i < 68; i++) x = x[0] ? (x + q) >> 1 : x >> 1;
    return x;
  endfunction

  task automatic launch(input logic [127:0] qh, input logic [127:0] c);
    bus.qH       = (LOGQ-W)'(qh);
    bus.C        = (2*LOGQ)'(c);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [127:0] exp);
    int lat;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      chk({tag, "_busy_in_ready"}, bus.in_ready, 1'b0);
      step();
      lat++;
    end
    chk({tag, "_latency"}, 128'(lat), 128'(LAT));
    chk({tag, "_T"}, bus.T, exp);
  endtask

  task automatic release_out(input string tag);
    bus.out_ready = 1'b1;
    step();
    chk({tag, "_drop_valid"}, bus.out_valid, 1'b0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] p68, p85, qm, cr, qh;
    int cnt, sent, rcvd, cyc;
    bit clr;
    p68 = 128'd1 << 68;
    p85 = 128'd1 << 85;

    // Reset state
    rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.qH = '0; bus.C = '0;
    step(); step();
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_T", bus.T, 128'd0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    rst = 1'b0;

    // Reset during RUN drops the job
    launch(128'd1, p68);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstrun_in_ready", bus.in_ready, 1'b1);
    chk("rstrun_out_valid", bus.out_valid, 1'b0);
    bus.out_ready = 1'b1;
    cnt = 0;
    repeat (10) begin step(); if (bus.out_valid === 1'b1) cnt++; end
    chk("rstrun_no_result", 128'(cnt), 128'd0);
    bus.out_ready = 1'b0;

    // Basic reductions
    launch(128'd1, p68);                 wait_result("q1_c68", 128'd1);          release_out("q1_c68");
    launch(128'd1, p85);                 wait_result("q1_c85", 128'h20000);      release_out("q1_c85");
    launch((128'd1 << 43) - 1, p68);     wait_result("qbig_c68", 128'd1);        release_out("qbig_c68");
    launch(128'd5, 128'd0);              wait_result("c0", 128'd0);              release_out("c0");

    // Backpressure then same-edge handshake and accept
    launch(128'd1, p68);
    wait_result("bp_first", 128'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_T", bus.T, 128'd1);
      chk("bp_hold_valid", bus.out_valid, 1'b1);
      chk("bp_hold_in_ready", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.qH = 43'd1; bus.C = 120'(p68);
    #1;
    chk("bp_comb_in_ready", bus.in_ready, 1'b1);
    step();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    chk("bp_after_hs_valid", bus.out_valid, 1'b0);
    wait_result("bp_second", 128'd1);
    release_out("bp_second");

    // qH changes during RUN are ignored
    launch(128'd1, p68);
    bus.qH = 43'd7;
    wait_result("qhchg_c68", 128'd1);
    release_out("qhchg_c68");
    launch(128'd1, 128'd12345);
    bus.qH = 43'd7;
    wait_result("qhchg_c12345", 128'd12345);
    release_out("qhchg_c12345");

    // Random regression with handshake gaps
    sent = 0; rcvd = 0; cyc = 0;
    bus.in_valid = 1'b0;
    while ((sent < 1000 || expq.size() != 0) && cyc < 60000) begin
      if (bus.in_valid !== 1'b1 && sent < 1000 && $urandom_range(0, 9) < 7) begin
        qh = 128'({$urandom(), $urandom()}) & ((128'd1 << 43) - 1);
        if ($urandom_range(0, 3) == 0) qh = 128'($urandom_range(0, 15));
        qm = (qh << 17) | 128'd1;
        cr = {$urandom(), $urandom(), $urandom(), $urandom()} % (qm * qm);
        bus.qH = 43'(qh); bus.C = 120'(cr); bus.in_valid = 1'b1;
      end
      bus.out_ready = ($urandom_range(0, 9) < 6);
      #1;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        chk("rnd_expected_pending", 128'(expq.size() != 0), 128'd1);
        if (expq.size() != 0) begin
          chk("rnd_T", bus.T, expq.pop_front());
          rcvd++;
        end
      end
      clr = 1'b0;
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        expq.push_back(gold(128'(bus.qH), 128'(bus.C)));
        sent++;
        clr = 1'b1;
      end
      step();
      cyc++;
      if (clr) bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    chk("rnd_received", 128'(rcvd), 128'd1000);
    chk("rnd_leftover", 128'(expq.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wlm_iter.md
Name: wlm_iter

Overview:
Iterative word-level Montgomery reducer for NTT-friendly moduli q = qH*2^W + 1, with the modulus supplied at run time.
- Trades the fully unrolled pipeline for one W-bit reduction step per cycle. Area scales with W, not LOGQ.
- Valid/ready handshakes on input and output, with backpressure.
- Sits after the wide multiplier in area-constrained NTT butterflies.

Parameters:
LOGQ, 60, modulus width in bits; C is 2*LOGQ bits.
W, 17, reduction word width; q ≡ 1 mod 2^W.
L, ceil(LOGQ/W) (derived localparam, 4 at defaults), number of reduction iterations; result is C*2^(-W*L) mod q.

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  synchronous active-high reset.
in_valid  in  1  C/qH valid.
in_ready  out  1  block can accept.
qH  in  LOGQ-W  high part of modulus; q = {qH, (W-1)'b0, 1'b1}.
C  in  2*LOGQ  operand; requirement: C < q*2^(W*L).
out_valid  out  1  T valid.
out_ready  in  1  consumer accepts T.
T  out  LOGQ  result in [0, q-1].

Behaviour:
- Reset: state=IDLE, out_valid=0, T=0, accumulator/counter cleared. in_ready=1 after the reset edge. Reset mid-operation drops the in-flight job; no out_valid is produced for it.
- FSM states: IDLE, RUN, CORR, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is a combinational path from out_ready, and it is allowed.
- Accept edge (in_valid && in_ready):
  - acc <= C, zero-extended to 2*LOGQ+1 bits.
  - qh_r <= qH; cnt <= 0; state <= RUN.
  - qH is sampled only here; changes during RUN are ignored.
- RUN, one iteration per edge:
  - lo = acc[W-1:0]; m = (2^W - lo) mod 2^W; c = (lo != 0).
  - acc <= (acc >> W) + qh_r*m + c. This is exact (acc + m*q)/2^W because q ≡ 1 mod 2^W.
  - cnt++. On the edge where cnt reaches L-1 the iteration completes and state <= CORR.
- CORR, one edge:
  - R = acc, with R < 2q guaranteed.
  - T <= (R >= q) ? R - q : R; out_valid <= 1; state <= DONE.
- Latency: out_valid rises L+1 edges after the accept edge (5 at defaults).
- DONE:
  - T and out_valid are held stable while out_ready=0, for an unlimited number of cycles.
  - On out_valid && out_ready: out_valid <= 0, and state <= IDLE, or RUN if a new accept happens on the same edge.
  - Back-to-back throughput is 1 result per L+2 cycles.
- in_valid in RUN/CORR is ignored: in_ready=0 and no capture.
- out_ready while out_valid=0 has no effect.
- Width rules:
  - qh_r*m is (LOGQ-W)+W = LOGQ bits.
  - The accumulator is 2*LOGQ+1 bits and never overflows while C < q*2^(W*L).
  - The comparison and subtraction are LOGQ+1 bits wide.
- C ≥ q*2^(W*L) is out of contract; the result is unspecified but the FSM still completes normally.

Decomposition:
- Package wlm_iter_pkg holds:
  - the state enum (IDLE, RUN, CORR, DONE);
  - a function clog-style ceil_div(a, b) for L;
  - localparam helpers for accumulator width.
- Sub-module wlm_step: combinational single iteration (acc, qh, W) -> acc_next. Reused by a later unrolled variant.
- The FSM, counter and correction stay in wlm_iter.

Test Plan:
All scenarios use the default parameters.
1. Reset: hold rst 2 cycles → out_valid=0, T=0, in_ready=1. Assert rst during RUN → next cycle state IDLE, in_ready=1, no out_valid ever produced for the dropped job.
2. qH=1 (q=131073), C=2^68 → T=1, out_valid exactly 5 edges after accept; in_ready=0 throughout RUN/CORR.
3. qH=1, C=2^85 → T=0x20000 (q-1). qH=2^43-1, C=2^68 → T=1. C=0 → T=0.
4. Backpressure: out_ready=0 for 10 cycles after out_valid → T and out_valid stable, in_ready=0. Then out_ready=1 with in_valid=1, C=2^68, qH=1 → handshake and new accept on the same edge; next T=1 after 5 more edges.
5. qH changed during RUN (1 → 7) → result still computed with qH=1 (T=1 for C=2^68).
6. Random regression: 1000 vectors with random qH and C < q^2, and random in_valid/out_ready gaps → T == C*2^(-68) mod q against the golden model, with no lost or duplicated results.
